// File: rtl/jtag_dtm_tap_responder.sv
// RISC-V Debug Transport Module (0.13), target side.
// The JTAG pins are oversampled in the CLK domain. A 16-state TAP controller
// with IDCODE/DTMCS/DMI/BYPASS data registers turns DMI scans into a
// valid/ready request/response exchange with the debug module.
module jtag_dtm_tap_responder #(
  parameter logic [31:0] IDCODE      = 32'h1000_1CFD,
  parameter int unsigned ABITS       = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TCK,
  input  logic             TMS,
  input  logic             TDI,
  input  logic             TRST,
  output logic             TDO,
  output logic             DMI_REQ_VALID,
  input  logic             DMI_REQ_READY,
  output logic [ABITS-1:0] DMI_REQ_ADDR,
  output logic [31:0]      DMI_REQ_DATA,
  output logic [1:0]       DMI_REQ_OP,
  input  logic             DMI_RSP_VALID,
  output logic             DMI_RSP_READY,
  input  logic [31:0]      DMI_RSP_DATA,
  input  logic [1:0]       DMI_RSP_OP
);

  localparam int unsigned DMI_W      = ABITS + 34;
  localparam logic [5:0]  ABITS_F    = 6'(ABITS);
  localparam logic [4:0]  IR_IDCODE  = 5'h01;
  localparam logic [4:0]  IR_DTMCS   = 5'h10;
  localparam logic [4:0]  IR_DMI     = 5'h11;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_t;

  typedef enum logic [1:0] {SEL_IDCODE, SEL_DTMCS, SEL_DMI, SEL_BYPASS} dr_sel_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and TCK edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
  logic tck_q;
  logic tck_s, tms_s, tdi_s, trst_s;
  logic rise, fall, tap_rst;

  // Shift the raw JTAG pins through the synchroniser chains
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tck_sync  <= '0;
      tms_sync  <= '0;
      tdi_sync  <= '0;
      trst_sync <= '0;
      tck_q     <= 1'b0;
    end else begin
      tck_sync[0]  <= TCK;
      tms_sync[0]  <= TMS;
      tdi_sync[0]  <= TDI;
      trst_sync[0] <= TRST;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        tck_sync[i]  <= tck_sync[i-1];
        tms_sync[i]  <= tms_sync[i-1];
        tdi_sync[i]  <= tdi_sync[i-1];
        trst_sync[i] <= trst_sync[i-1];
      end
      tck_q <= tck_s;
    end
  end

  assign tck_s   = tck_sync[SYNC_STAGES-1];
  assign tms_s   = tms_sync[SYNC_STAGES-1];
  assign tdi_s   = tdi_sync[SYNC_STAGES-1];
  assign trst_s  = trst_sync[SYNC_STAGES-1];
  assign rise    = tck_s & ~tck_q;
  assign fall    = ~tck_s & tck_q;
  assign tap_rst = RESET | trst_s;

  // ---------------------------------------------------------------------------
  // TAP controller
  // ---------------------------------------------------------------------------
  tap_state_t state, state_nxt;
  logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

  // State register, advanced on each synchronised TCK rise
  always_ff @(posedge CLK) begin
    if (tap_rst) begin
      state <= TEST_LOGIC_RESET;
    end else if (rise) begin
      state <= state_nxt;
    end
  end

  // Standard TAP transition table driven by the synchronised TMS
  always_comb begin
    state_nxt = state;
    unique case (state)
      TEST_LOGIC_RESET: state_nxt = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_nxt = tms_s ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        state_nxt = tms_s ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       state_nxt = tms_s ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         state_nxt = tms_s ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         state_nxt = tms_s ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         state_nxt = tms_s ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         state_nxt = tms_s ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        state_nxt = tms_s ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        state_nxt = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_nxt = tms_s ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         state_nxt = tms_s ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         state_nxt = tms_s ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         state_nxt = tms_s ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         state_nxt = tms_s ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        state_nxt = tms_s ? SELECT_DR : RUN_TEST_IDLE;
      default:          state_nxt = TEST_LOGIC_RESET;
    endcase
  end

  // One-CLK action strobes, fired on the rise that leaves each state
  always_comb begin
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    if (rise) begin
      case (state)
        CAPTURE_DR: capture_dr = 1'b1;
        SHIFT_DR:   shift_dr   = 1'b1;
        UPDATE_DR:  update_dr  = 1'b1;
        CAPTURE_IR: capture_ir = 1'b1;
        SHIFT_IR:   shift_ir   = 1'b1;
        UPDATE_IR:  update_ir  = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction register
  // ---------------------------------------------------------------------------
  logic [4:0] ir_sr, ir;
  dr_sel_t    dr_sel;

  // IR shift stage and latched instruction
  always_ff @(posedge CLK) begin
    if (tap_rst) begin
      ir_sr <= '0;
      ir    <= IR_IDCODE;
    end else begin
      if (capture_ir) ir_sr <= 5'b00001;
      if (shift_ir)   ir_sr <= {tdi_s, ir_sr[4:1]};
      if (state == TEST_LOGIC_RESET) ir <= IR_IDCODE;
      else if (update_ir)            ir <= ir_sr;
    end
  end

  // Map the instruction onto a data register
  always_comb begin
    dr_sel = SEL_BYPASS;
    case (ir)
      IR_IDCODE: dr_sel = SEL_IDCODE;
      IR_DTMCS:  dr_sel = SEL_DTMCS;
      IR_DMI:    dr_sel = SEL_DMI;
      default:   dr_sel = SEL_BYPASS;
    endcase
  end

  // ---------------------------------------------------------------------------
  // DMI transaction state
  // ---------------------------------------------------------------------------
  logic             req_valid, rsp_ready, busy;
  logic [ABITS-1:0] req_addr, last_addr;
  logic [31:0]      req_data, rsp_data;
  logic [1:0]       req_op, sticky, sticky_nxt;
  logic             rsp_hs, dtmcs_update, dmi_update_req;
  logic [31:0]      dtmcs_cap, cap_rsp_data;
  logic [1:0]       cap_status;
  logic [DMI_W-1:0] dr_sr;

  assign rsp_hs         = DMI_RSP_VALID & rsp_ready;
  assign dtmcs_update   = update_dr && (dr_sel == SEL_DTMCS);
  assign dmi_update_req = update_dr && (dr_sel == SEL_DMI) &&
                          (dr_sr[1:0] == 2'd1 || dr_sr[1:0] == 2'd2);

  // Sticky error status; a busy collision outranks a failed response
  always_comb begin
    sticky_nxt = sticky;
    if (rsp_hs && DMI_RSP_OP != 2'd0 && sticky != 2'd3) sticky_nxt = 2'd2;
    if (dtmcs_update && (dr_sr[16] || dr_sr[17]))       sticky_nxt = 2'd0;
    if (dmi_update_req && busy)                         sticky_nxt = 2'd3;
  end

  // Capture view reflects a response handshake landing in the same CLK
  always_comb begin
    cap_rsp_data = rsp_hs ? DMI_RSP_DATA : rsp_data;
    cap_status   = (busy && !rsp_hs) ? 2'd3 : sticky_nxt;
    dtmcs_cap    = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, sticky, ABITS_F, 4'd1};
  end

  // ---------------------------------------------------------------------------
  // Data register shift stage
  // ---------------------------------------------------------------------------
  // Capture and shift the selected DR; shorter registers use the low bits
  always_ff @(posedge CLK) begin
    if (tap_rst) begin
      dr_sr <= '0;
    end else if (capture_dr) begin
      case (dr_sel)
        SEL_IDCODE: dr_sr <= DMI_W'(IDCODE);
        SEL_DTMCS:  dr_sr <= DMI_W'(dtmcs_cap);
        SEL_DMI:    dr_sr <= {last_addr, cap_rsp_data, cap_status};
        default:    dr_sr <= '0;
      endcase
    end else if (shift_dr) begin
      case (dr_sel)
        SEL_DMI:    dr_sr <= {tdi_s, dr_sr[DMI_W-1:1]};
        SEL_BYPASS: dr_sr <= DMI_W'(tdi_s);
        default:    dr_sr <= DMI_W'({tdi_s, dr_sr[31:1]});
      endcase
    end
  end

  // TDO updates on TCK fall only while shifting
  always_ff @(posedge CLK) begin
    if (tap_rst) begin
      TDO <= 1'b0;
    end else if (fall) begin
      if (state == SHIFT_IR)      TDO <= ir_sr[0];
      else if (state == SHIFT_DR) TDO <= dr_sr[0];
    end
  end

  // Request/response handshake with the debug module
  always_ff @(posedge CLK) begin
    if (tap_rst) begin
      req_valid <= 1'b0;
      rsp_ready <= 1'b0;
      busy      <= 1'b0;
      sticky    <= '0;
      if (RESET) begin
        req_addr  <= '0;
        req_data  <= '0;
        req_op    <= '0;
        last_addr <= '0;
        rsp_data  <= '0;
      end
    end else begin
      sticky <= sticky_nxt;
      if (req_valid && DMI_REQ_READY) begin
        req_valid <= 1'b0;
        rsp_ready <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_data  <= DMI_RSP_DATA;
        rsp_ready <= 1'b0;
        busy      <= 1'b0;
      end
      // Hard reset drops the transaction; deasserting ready discards any late response
      if (dtmcs_update && dr_sr[17]) begin
        req_valid <= 1'b0;
        rsp_ready <= 1'b0;
        busy      <= 1'b0;
      end
      if (dmi_update_req && !busy && sticky == 2'd0) begin
        req_addr  <= dr_sr[DMI_W-1:34];
        req_data  <= dr_sr[33:2];
        req_op    <= dr_sr[1:0];
        last_addr <= dr_sr[DMI_W-1:34];
        req_valid <= 1'b1;
        busy      <= 1'b1;
      end
    end
  end

  assign DMI_REQ_VALID = req_valid;
  assign DMI_REQ_ADDR  = req_addr;
  assign DMI_REQ_DATA  = req_data;
  assign DMI_REQ_OP    = req_op;
  assign DMI_RSP_READY = rsp_ready;

endmodule

// File: tb/tb_jtag_dtm_tap_responder.sv
// Directed bench for jtag_dtm_tap_responder: bit-banged JTAG scans with a
// request scoreboard on the DMI side.
module tb_jtag_dtm_tap_responder;

  localparam int unsigned ABITS = 7;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } req_t;

  logic        CLK = 1'b0;
  logic        RESET, TCK, TMS, TDI, TRST;
  logic        TDO;
  logic        DMI_REQ_VALID, DMI_REQ_READY;
  logic [6:0]  DMI_REQ_ADDR;
  logic [31:0] DMI_REQ_DATA;
  logic [1:0]  DMI_REQ_OP;
  logic        DMI_RSP_VALID, DMI_RSP_READY;
  logic [31:0] DMI_RSP_DATA;
  logic [1:0]  DMI_RSP_OP;

  int   errors = 0;
  int   checks = 0;
  req_t exp_q[$];

  always #5 CLK = ~CLK;

  jtag_dtm_tap_responder #(
    .IDCODE(32'h1000_1CFD),
    .ABITS(ABITS),
    .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TRST(TRST),
    .TDO(TDO),
    .DMI_REQ_VALID(DMI_REQ_VALID), .DMI_REQ_READY(DMI_REQ_READY),
    .DMI_REQ_ADDR(DMI_REQ_ADDR), .DMI_REQ_DATA(DMI_REQ_DATA), .DMI_REQ_OP(DMI_REQ_OP),
    .DMI_RSP_VALID(DMI_RSP_VALID), .DMI_RSP_READY(DMI_RSP_READY),
    .DMI_RSP_DATA(DMI_RSP_DATA), .DMI_RSP_OP(DMI_RSP_OP)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One TCK period; tdo_s is TDO as seen just before the rising edge
  task automatic tick(input logic tms, input logic tdi, output logic tdo_s);
    TMS = tms;
    TDI = tdi;
    clk_wait(3);
    tdo_s = TDO;
    TCK = 1'b1;
    clk_wait(6);
    TCK = 1'b0;
    clk_wait(6);
  endtask

  task automatic tap_reset_to_idle();
    logic b;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
  endtask

  task automatic scan_ir(input logic [4:0] v, output logic [4:0] cap);
    logic b;
    tick(1'b1, 1'b0, b);
    tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
    tick(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) begin
      tick(i == 4, v[i], b);
      cap[i] = b;
    end
    tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
  endtask

  task automatic scan_dr(input logic [63:0] din, input int len, output logic [63:0] dout);
    logic b;
    dout = '0;
    tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
    tick(1'b0, 1'b0, b);
    for (int i = 0; i < len; i++) begin
      tick(i == len - 1, din[i], b);
      dout[i] = b;
    end
    tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
  endtask

  task automatic dmi_scan(input logic [6:0] a, input logic [31:0] dat, input logic [1:0] op,
                          input bit expect_req, output logic [40:0] cap);
    req_t r;
    logic [63:0] d;
    r = '{addr: a, data: dat, op: op};
    if (expect_req) exp_q.push_back(r);
    scan_dr(64'(r), 41, d);
    cap = d[40:0];
  endtask

  task automatic accept_request();
    DMI_REQ_READY = 1'b1;
    clk_wait(1);
    DMI_REQ_READY = 1'b0;
  endtask

  task automatic send_response(input logic [31:0] dat, input logic [1:0] op);
    DMI_RSP_VALID = 1'b1;
    DMI_RSP_DATA  = dat;
    DMI_RSP_OP    = op;
    clk_wait(1);
    DMI_RSP_VALID = 1'b0;
  endtask

  // Request scoreboard and stall-stability monitor, sampled mid-cycle
  logic stalled_prev = 1'b0;
  req_t held;
  always @(negedge CLK) begin
    req_t got, want;
    got = '{addr: DMI_REQ_ADDR, data: DMI_REQ_DATA, op: DMI_REQ_OP};
    if (stalled_prev && DMI_REQ_VALID === 1'b1) check("req_stable", 64'(got), 64'(held));
    if (DMI_REQ_VALID === 1'b1 && DMI_REQ_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("req_expected", 64'(exp_q.size()), 64'd1);
      end else begin
        want = exp_q.pop_front();
        check("req_fields", 64'(got), 64'(want));
      end
    end
    stalled_prev = (DMI_REQ_VALID === 1'b1) && (DMI_REQ_READY === 1'b0);
    held = got;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [40:0] cap;
    logic [4:0]  irc;
    logic        b;

    RESET = 1'b1; TCK = 1'b0; TMS = 1'b0; TDI = 1'b0; TRST = 1'b0;
    DMI_REQ_READY = 1'b0; DMI_RSP_VALID = 1'b0; DMI_RSP_DATA = '0; DMI_RSP_OP = '0;
    clk_wait(5);
    RESET = 1'b0;
    clk_wait(2);

    check("rst_tdo",       64'(TDO), 64'd0);
    check("rst_req_valid", 64'(DMI_REQ_VALID), 64'd0);
    check("rst_rsp_ready", 64'(DMI_RSP_READY), 64'd0);
    check("rst_req_fields", 64'({DMI_REQ_ADDR, DMI_REQ_DATA, DMI_REQ_OP}), 64'd0);

    // IDCODE is the default instruction
    tap_reset_to_idle();
    scan_dr(64'd0, 32, d);
    check("idcode", 64'(d[31:0]), 64'h1000_1CFD);

    // BYPASS delays TDI by one TCK
    scan_ir(5'h1F, irc);
    check("ir_capture", 64'(irc), 64'd1);
    scan_dr(64'h00A5, 16, d);
    check("bypass", 64'(d[15:0]), 64'h014A);

    scan_ir(5'h10, irc);
    scan_dr(64'd0, 32, d);
    check("dtmcs_reset", 64'(d[31:0]), 64'h0000_1071);

    // DMI write with a stalled request
    scan_ir(5'h11, irc);
    dmi_scan(7'h10, 32'hDEAD_BEEF, 2'd2, 1'b1, cap);
    check("dmi_first_capture", 64'(cap), 64'd0);
    check("req_valid_up", 64'(DMI_REQ_VALID), 64'd1);
    check("req_addr", 64'(DMI_REQ_ADDR), 64'h10);
    check("req_data", 64'(DMI_REQ_DATA), 64'hDEAD_BEEF);
    check("req_op",   64'(DMI_REQ_OP), 64'd2);
    for (int i = 0; i < 3; i++) begin
      clk_wait(1);
      check("req_held", 64'(DMI_REQ_VALID), 64'd1);
    end
    accept_request();
    check("req_dropped", 64'(DMI_REQ_VALID), 64'd0);
    check("rsp_ready_up", 64'(DMI_RSP_READY), 64'd1);
    send_response(32'hCAFE_F00D, 2'd0);
    check("rsp_ready_down", 64'(DMI_RSP_READY), 64'd0);
    dmi_scan(7'h10, 32'd0, 2'd0, 1'b0, cap);
    check("dmi_capture_ok", 64'(cap), 64'({7'h10, 32'hCAFE_F00D, 2'd0}));

    // Second scan while the response is outstanding
    dmi_scan(7'h05, 32'h1111_2222, 2'd2, 1'b1, cap);
    check("dmi_capture_prev", 64'(cap), 64'({7'h10, 32'hCAFE_F00D, 2'd0}));
    accept_request();
    check("rsp_ready_wait", 64'(DMI_RSP_READY), 64'd1);
    dmi_scan(7'h06, 32'd0, 2'd1, 1'b0, cap);
    check("dmi_capture_busy", 64'(cap), 64'({7'h05, 32'hCAFE_F00D, 2'd3}));
    clk_wait(2);
    check("no_req_when_busy", 64'(DMI_REQ_VALID), 64'd0);
    send_response(32'h0BAD_0BAD, 2'd0);

    scan_ir(5'h10, irc);
    scan_dr(64'd0, 32, d);
    check("dtmcs_sticky", 64'(d[31:0]), 64'h0000_1C71);
    scan_dr(64'h0001_0000, 32, d);
    check("dtmcs_before_clear", 64'(d[31:0]), 64'h0000_1C71);
    scan_dr(64'd0, 32, d);
    check("dtmcs_cleared", 64'(d[31:0]), 64'h0000_1071);

    // Read after the sticky status is cleared
    scan_ir(5'h11, irc);
    dmi_scan(7'h20, 32'd0, 2'd1, 1'b1, cap);
    check("dmi_capture_rsp2", 64'(cap), 64'({7'h05, 32'h0BAD_0BAD, 2'd0}));
    accept_request();
    send_response(32'h1234_5678, 2'd0);
    dmi_scan(7'h20, 32'd0, 2'd0, 1'b0, cap);
    check("dmi_read_data", 64'(cap), 64'({7'h20, 32'h1234_5678, 2'd0}));

    // TRST in the middle of a DR shift with a request pending
    dmi_scan(7'h33, 32'hA5A5_A5A5, 2'd2, 1'b0, cap);
    check("dmi_capture_pre_trst", 64'(cap), 64'({7'h20, 32'h1234_5678, 2'd0}));
    clk_wait(2);
    check("req_pending", 64'(DMI_REQ_VALID), 64'd1);
    tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
    tick(1'b0, 1'b0, b);
    tick(1'b0, 1'b1, b);
    tick(1'b0, 1'b1, b);
    TRST = 1'b1;
    clk_wait(4);
    check("trst_req_valid", 64'(DMI_REQ_VALID), 64'd0);
    check("trst_rsp_ready", 64'(DMI_RSP_READY), 64'd0);
    check("trst_tdo", 64'(TDO), 64'd0);
    TRST = 1'b0;
    clk_wait(4);
    tick(1'b0, 1'b0, b);
    scan_dr(64'd0, 32, d);
    check("idcode_after_trst", 64'(d[31:0]), 64'h1000_1CFD);

    clk_wait(4);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
